inst_fetch_unit: RTL and testbench

- Initiator side of the instruction memory interface.
- Owns the program counter and drives the word-aligned fetch address to the combinational instruction memory.
- Captures the returned instruction in the same cycle and buffers {pc, inst} pairs in a small FIFO.
- Hands those pairs to decode over a valid/ready handshake, and supports branch/jump redirect with flush.

---
 rtl/inst_fetch_unit_pkg.sv | 23 ++
 rtl/inst_fetch_unit_if.sv | 45 ++++
 rtl/inst_fetch_unit_fetch_buffer.sv | 69 ++++++
 rtl/inst_fetch_unit.sv | 117 +++++++++++
 tb/tb_inst_fetch_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INST_WIDTH / INST_MEMORY_ADDRESS_WIDTH / INST_BYTE_WIDTH : memory geometry
//   PC_STEP       : byte increment between sequential fetches
//   fetch_entry_t : one buffered {pc, inst} pair handed to decode
//   fetch_state_e : FETCH (normal) / HALT (after a misaligned redirect)
package inst_fetch_unit_pkg;

   localparam int INST_WIDTH                = 32;
   localparam int INST_MEMORY_ADDRESS_WIDTH = 16;
   localparam int INST_BYTE_WIDTH           = INST_WIDTH / 8;
   localparam int PC_STEP                   = 4;

   typedef struct packed {
      logic [INST_MEMORY_ADDRESS_WIDTH-1:0] pc;
      logic [INST_WIDTH-1:0]                inst;
   } fetch_entry_t;

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory, execute and decode.
//   master : the fetch unit (drives inst_add, fd_*, misaligned_err)
//   slave  : the surrounding core (drives inst_data, redirect_*, fd_ready)
interface inst_fetch_unit_if
   import inst_fetch_unit_pkg::*;
#(
   parameter int ADDR_W = INST_MEMORY_ADDRESS_WIDTH,
   parameter int INST_W = INST_WIDTH
);

   logic [ADDR_W-1:0] inst_add;
   logic [INST_W-1:0] inst_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              fd_valid;
   logic              fd_ready;
   logic [INST_W-1:0] fd_inst;
   logic [ADDR_W-1:0] fd_pc;
   logic              misaligned_err;

   modport master (
      output inst_add,
      input  inst_data,
      input  redirect_valid,
      input  redirect_pc,
      output fd_valid,
      input  fd_ready,
      output fd_inst,
      output fd_pc,
      output misaligned_err
   );

   modport slave (
      input  inst_add,
      output inst_data,
      output redirect_valid,
      output redirect_pc,
      input  fd_valid,
      output fd_ready,
      input  fd_inst,
      input  fd_pc,
      input  misaligned_err
   );

endinterface

// File: rtl/inst_fetch_unit_fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetch_entry_t, FB_DEPTH entries (2..8).
//   push/push_data : enqueue (ignored when full unless a pop happens too)
//   pop            : dequeue (ignored when empty)
//   flush          : empty the FIFO; wins over push and pop
//   count/full     : occupancy
//   head           : oldest entry, all zeros while empty
module fetch_buffer
   import inst_fetch_unit_pkg::*;
#(
   parameter  int FB_DEPTH = 2,
   localparam int CNT_W    = $clog2(FB_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head,
   output logic             full
);

   localparam int PTR_W = $clog2(FB_DEPTH);

   fetch_entry_t     mem [FB_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count_q == CNT_W'(FB_DEPTH));
   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && (!full || do_pop);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is not reset; head is masked while empty so stale words never reach decode.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_q] <= push_data;
   end

   assign count = count_q;
   assign head  = (count_q != '0) ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-memory initiator. Owns the PC, reads the
// combinational instruction memory every cycle it has buffer room, and hands
// {pc, inst} pairs to decode over valid/ready. A redirect flushes the buffer
// and reloads the PC; a misaligned redirect parks the unit in HALT until reset.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (master) : inst_add/inst_data, redirect_valid/redirect_pc,
//                  fd_valid/fd_ready/fd_inst/fd_pc, misaligned_err
//   perf_fetch_cnt, perf_stall_cnt : saturating counters, present only when
//                  FETCH_PERF_CNT_EN is defined
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int unsigned RESET_PC = 0,
   parameter int          FB_DEPTH = 2,
   parameter int          ADDR_W   = INST_MEMORY_ADDRESS_WIDTH,
   parameter int          INST_W   = INST_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   inst_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   localparam int CNT_W = $clog2(FB_DEPTH + 1);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              redirect_take, misaligned;
   logic              push, pop, flush, full;
   logic [CNT_W-1:0]  count;
   fetch_entry_t      head, push_data;

   // Redirects are only honoured while fetching; HALT ignores them.
   assign redirect_take = (state_q == FETCH) && bus.redirect_valid;
   assign misaligned    = (bus.redirect_pc[1:0] != 2'b00);

   assign bus.fd_valid  = (state_q == FETCH) && (count != '0);
   // A redirect cycle discards the handshake: the head is flushed, not consumed.
   assign pop           = bus.fd_valid && bus.fd_ready && !redirect_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= ADDR_W'(RESET_PC);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (redirect_take && misaligned) state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned.
   always_comb begin
      push  = 1'b0;
      flush = 1'b0;
      pc_d  = pc_q;
      case (state_q)
         FETCH: begin
            if (bus.redirect_valid) begin
               flush = 1'b1;
               pc_d  = bus.redirect_pc;
            end else if (!full || pop) begin
               push = 1'b1;
               pc_d = pc_q + ADDR_W'(PC_STEP);
            end
         end
         default: ;
      endcase
   end

   // Memory is combinational, so the word fetched at pc_q is captured this cycle.
   assign bus.inst_add       = pc_q;
   assign push_data.pc       = pc_q;
   assign push_data.inst     = bus.inst_data;
   assign bus.fd_inst        = head.inst;
   assign bus.fd_pc          = head.pc;
   assign bus.misaligned_err = (state_q == HALT);

   fetch_buffer #(.FB_DEPTH(FB_DEPTH)) u_fetch_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .count     (count),
      .head      (head),
      .full      (full)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (push && (perf_fetch_cnt != '1))
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if ((state_q == FETCH) && full && !pop && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
module tb_inst_fetch_unit;
   import inst_fetch_unit_pkg::*;

   localparam int AW = INST_MEMORY_ADDRESS_WIDTH;
   localparam int IW = INST_WIDTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inst_fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   inst_fetch_unit #(
      .RESET_PC (0),
      .FB_DEPTH (2),
      .ADDR_W   (AW),
      .INST_W   (IW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   // Instruction memory model: address-dependent word, never zero.
   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return IW'({a ^ AW'(16'h5A3C), ~a});
   endfunction

   assign bus.inst_data = mem_word(bus.inst_add);

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Scoreboard of expected fd_pc values, in presentation order.
   logic [AW-1:0] exp_q [$];

   always @(negedge clk) begin
      if (rst_n && bus.fd_valid && bus.fd_ready && !bus.redirect_valid) begin
         check("sb_expected_output", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            logic [AW-1:0] e;
            e = exp_q.pop_front();
            check("sb_pc", bus.fd_pc, e);
            check("sb_inst", bus.fd_inst, mem_word(e));
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid_cycle();
      @(negedge clk);
   endtask

   task automatic expect_seq(input logic [AW-1:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + AW'(4 * i));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.fd_ready       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      rst_n              = 1'b0;
      repeat (2) @(posedge clk);
      mid_cycle();
      check("rst_fd_valid", bus.fd_valid, 0);
      check("rst_fd_inst", bus.fd_inst, 0);
      check("rst_fd_pc", bus.fd_pc, 0);
      check("rst_err", bus.misaligned_err, 0);
      check("rst_inst_add", bus.inst_add, 0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_perf_fetch", perf_fetch_cnt, 0);
      check("rst_perf_stall", perf_stall_cnt, 0);
`endif

      // Startup with decode stalled: fetch 0x0, 0x4, then hold at 0x8.
      next_cycle();
      rst_n = 1'b1;
      mid_cycle();
      check("start_add0", bus.inst_add, 'h0);
      check("start_valid0", bus.fd_valid, 0);
      next_cycle();
      mid_cycle();
      check("start_add1", bus.inst_add, 'h4);
      check("start_valid1", bus.fd_valid, 1);
      check("start_pc1", bus.fd_pc, 'h0);
      check("start_inst1", bus.fd_inst, mem_word('h0));
      for (int i = 2; i <= 4; i++) begin
         next_cycle();
         mid_cycle();
         check("bp_hold_add", bus.inst_add, 'h8);
         check("bp_head_pc", bus.fd_pc, 'h0);
      end

      // Release backpressure: 0x0..0x14 in order, one per cycle.
      next_cycle();
      bus.fd_ready = 1'b1;
      expect_seq('h0, 6);
      for (int i = 0; i < 6; i++) begin
         mid_cycle();
         next_cycle();
      end
      check("sb_drain_stream", exp_q.size(), 0);

      // Fill the buffer, then redirect to 0x40 with ready high.
      bus.fd_ready = 1'b0;
      mid_cycle();
      check("pre_redirect_valid", bus.fd_valid, 1);
      next_cycle();
      bus.fd_ready       = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 'h40;
      mid_cycle();
      next_cycle();
      bus.redirect_valid = 1'b0;
      expect_seq('h40, 3);
      mid_cycle();
      check("redir_valid_n1", bus.fd_valid, 0);
      check("redir_add_n1", bus.inst_add, 'h40);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         mid_cycle();
      end
      next_cycle();
      check("sb_drain_redirect", exp_q.size(), 0);

      // Wrap-around from the last word.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 'hFFFC;
      mid_cycle();
      next_cycle();
      bus.redirect_valid = 1'b0;
      expect_seq('hFFFC, 3);
      mid_cycle();
      check("wrap_add_top", bus.inst_add, 'hFFFC);
      next_cycle();
      mid_cycle();
      check("wrap_add_zero", bus.inst_add, 'h0);
      check("wrap_no_err", bus.misaligned_err, 0);
      next_cycle();
      mid_cycle();
      next_cycle();
      mid_cycle();
      next_cycle();
      check("sb_drain_wrap", exp_q.size(), 0);

      // Misaligned redirect: sticky error, no output, later redirects ignored.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 'h42;
      mid_cycle();
      next_cycle();
      bus.redirect_valid = 1'b0;
      mid_cycle();
      check("mis_err_n1", bus.misaligned_err, 1);
      check("mis_valid_n1", bus.fd_valid, 0);
      check("mis_add_n1", bus.inst_add, 'h42);
      next_cycle();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 'h80;
      mid_cycle();
      next_cycle();
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mid_cycle();
         check("halt_err", bus.misaligned_err, 1);
         check("halt_valid", bus.fd_valid, 0);
         check("halt_add", bus.inst_add, 'h42);
         next_cycle();
      end
      #2 rst_n = 1'b0;
      #1;
      check("halt_rst_err", bus.misaligned_err, 0);
      check("halt_rst_add", bus.inst_add, 'h0);

      // Asynchronous reset with a full buffer.
      next_cycle();
      bus.fd_ready = 1'b0;
      rst_n        = 1'b1;
      next_cycle();
      next_cycle();
      mid_cycle();
      check("full_before_rst", bus.fd_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", bus.fd_valid, 0);
      check("async_rst_pc", bus.fd_pc, 0);
      check("async_rst_add", bus.inst_add, 'h0);
      next_cycle();
      rst_n        = 1'b1;
      bus.fd_ready = 1'b1;
      expect_seq('h0, 2);
      mid_cycle();
      check("rerun_add0", bus.inst_add, 'h0);
      next_cycle();
      mid_cycle();
      next_cycle();
      mid_cycle();
      next_cycle();
      bus.fd_ready = 1'b0;
      check("sb_drain_rerun", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
